// File: rtl/data_bus_ctrl.sv
// Data-bus controller: RAM plus LED/SEG/CYCLE/CMP/STATUS registers.
// Ports: clk, clr (async low), CPU port (ce/we/addr/sel/data), regs out.
module data_bus_ctrl #(
  parameter int RAM_AW = 10
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [3:0]  ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [15:0] led_o,
  output logic [31:0] seg_o,
  output logic        timer_irq_o,
  output logic        halt_o
);

  localparam logic [29:0] W_LED = 30'h0400_0000;
  localparam logic [29:0] W_SEG = 30'h0400_0001;
  localparam logic [29:0] W_CYC = 30'h0400_0002;
  localparam logic [29:0] W_CMP = 30'h0400_0003;
  localparam logic [29:0] W_STS = 30'h0400_0004;

  logic [31:0] ram [2**RAM_AW];

  logic [15:0] led;
  logic [31:0] seg;
  logic [31:0] cycle;
  logic [31:0] cmp;
  logic        flag;
  logic        halt;

  logic              rd;
  logic              wr;
  logic [29:0]       word;
  logic [RAM_AW-1:0] idx;
  logic [31:0]       mask;

  logic hit_ram;
  logic hit_led;
  logic hit_seg;
  logic hit_cyc;
  logic hit_cmp;
  logic hit_sts;

  logic [31:0] led_m;
  logic [31:0] seg_m;
  logic [31:0] cyc_m;
  logic [31:0] cmp_m;

  logic cmp_hit;
  logic w1c;
  logic halt_set;
  logic unused;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nv,
    input logic [31:0] m
  );
    return (old & ~m) | (nv & m);
  endfunction

  assign unused = ^addr_i[1:0];

  assign rd   = (|ce_i) & ~we_i;
  // sel_i==0 writes are dropped here so no target sees them
  assign wr   = (|ce_i) & we_i & (|sel_i);
  assign word = addr_i[31:2];
  assign idx  = addr_i[RAM_AW+1:2];

  assign mask = {{8{sel_i[3]}}, {8{sel_i[2]}},
                 {8{sel_i[1]}}, {8{sel_i[0]}}};

  assign hit_ram = (addr_i[31:28] == 4'h0);
  assign hit_led = (word == W_LED);
  assign hit_seg = (word == W_SEG);
  assign hit_cyc = (word == W_CYC);
  assign hit_cmp = (word == W_CMP);
  assign hit_sts = (word == W_STS);

  // LED only holds lanes 0-1
  assign led_m = merge({16'h0, led}, data_i,
                       mask & 32'h0000_ffff);
  assign seg_m = merge(seg, data_i, mask);
  assign cyc_m = merge(cycle, data_i, mask);
  assign cmp_m = merge(cmp, data_i, mask);

  // compare uses the pre-update count
  assign cmp_hit  = (cmp != 32'h0) && (cycle == cmp);
  assign w1c      = wr & hit_sts & sel_i[0] & data_i[0];
  assign halt_set = wr & hit_sts & sel_i[0] & data_i[1];

  // RAM is never cleared; the reset branch only blocks writes
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
    end else if (wr && hit_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) begin
          ram[idx][8*i +: 8] <= data_i[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      led <= '0;
      seg <= '0;
      cmp <= '0;
    end else begin
      if (wr && hit_led) begin
        led <= led_m[15:0];
      end
      if (wr && hit_seg) begin
        seg <= seg_m;
      end
      if (wr && hit_cmp) begin
        cmp <= cmp_m;
      end
    end
  end

  // a software write beats the free-running increment
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cycle <= '0;
    end else if (wr && hit_cyc) begin
      cycle <= cyc_m;
    end else if (!halt) begin
      cycle <= cycle + 32'd1;
    end
  end

  // set has priority over a same-edge clear
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      flag <= 1'b0;
    end else if (cmp_hit) begin
      flag <= 1'b1;
    end else if (w1c) begin
      flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      halt <= 1'b0;
    end else if (halt_set) begin
      halt <= 1'b1;
    end
  end

  always_comb begin
    data_o = '0;
    if (rd) begin
      unique case (1'b1)
        hit_ram: data_o = ram[idx];
        hit_led: data_o = {16'h0, led};
        hit_seg: data_o = seg;
        hit_cyc: data_o = cycle;
        hit_cmp: data_o = cmp;
        hit_sts: data_o = {30'h0, halt, flag};
        default: data_o = '0;
      endcase
    end
  end

  assign led_o       = led;
  assign seg_o       = seg;
  assign timer_irq_o = flag;
  assign halt_o      = halt;

endmodule

// File: tb/tb_data_bus_ctrl.sv
// Bench for data_bus_ctrl: directed table, corner sequences,
// and random traffic against a behavioural memory-map model.
module tb_data_bus_ctrl;

  localparam int AW = 10;

  localparam logic [31:0] A_LED = 32'h1000_0000;
  localparam logic [31:0] A_SEG = 32'h1000_0004;
  localparam logic [31:0] A_CYC = 32'h1000_0008;
  localparam logic [31:0] A_CMP = 32'h1000_000C;
  localparam logic [31:0] A_STS = 32'h1000_0010;

  logic        clk = 1'b0;
  logic        clr;
  logic [3:0]  ce_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic [15:0] led_o;
  logic [31:0] seg_o;
  logic        timer_irq_o;
  logic        halt_o;

  int checks = 0;
  int failures = 0;

  data_bus_ctrl #(.RAM_AW(AW)) dut (
    .clk(clk),
    .clr(clr),
    .ce_i(ce_i),
    .we_i(we_i),
    .addr_i(addr_i),
    .sel_i(sel_i),
    .data_i(data_i),
    .data_o(data_o),
    .led_o(led_o),
    .seg_o(seg_o),
    .timer_irq_o(timer_irq_o),
    .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  logic [31:0] m_ram [2**AW];
  logic [31:0] m_led;
  logic [31:0] m_seg;
  logic [31:0] m_cyc;
  logic [31:0] m_cmp;
  logic        m_flag;
  logic        m_halt;

  typedef struct {
    logic [3:0]  ce;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) m[8*i +: 8] = 8'hff;
    end
    return m;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (a[31:28] == 4'h0) return m_ram[a[AW+1:2]];
    if (wa == A_LED) return {16'h0, m_led[15:0]};
    if (wa == A_SEG) return m_seg;
    if (wa == A_CYC) return m_cyc;
    if (wa == A_CMP) return m_cmp;
    if (wa == A_STS) return {30'h0, m_halt, m_flag};
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_led = 0;
    m_seg = 0;
    m_cyc = 0;
    m_cmp = 0;
    m_flag = 0;
    m_halt = 0;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".led"}, {16'h0, led_o}, {16'h0, m_led[15:0]});
    chk({tag, ".seg"}, seg_o, m_seg);
    chk({tag, ".irq"}, {31'h0, timer_irq_o}, {31'h0, m_flag});
    chk({tag, ".halt"}, {31'h0, halt_o}, {31'h0, m_halt});
  endtask

  // One bus cycle; called and returning at a falling edge.
  task automatic op(input logic [3:0] ce, input logic we,
                    input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] r);
    logic [31:0] m, wa, n_led, n_seg, n_cyc, n_cmp;
    logic n_flag, n_halt, wr, set;
    ce_i = ce;
    we_i = we;
    addr_i = a;
    sel_i = s;
    data_i = d;
    #1;
    r = data_o;
    chk("rdata", data_o,
        (ce != 0 && !we) ? m_read(a) : 32'h0);
    m = lanes(s);
    wa = {a[31:2], 2'b00};
    wr = (ce != 0) && we;
    n_led = m_led;
    n_seg = m_seg;
    n_cmp = m_cmp;
    n_halt = m_halt;
    n_cyc = m_halt ? m_cyc : m_cyc + 1;
    set = (m_cmp != 0) && (m_cyc == m_cmp);
    n_flag = m_flag | set;
    if (wr) begin
      if (a[31:28] == 4'h0)
        m_ram[a[AW+1:2]] = (m_ram[a[AW+1:2]] & ~m) | (d & m);
      else if (wa == A_LED)
        n_led = (m_led & ~m & 32'hffff) | (d & m & 32'hffff);
      else if (wa == A_SEG) n_seg = (m_seg & ~m) | (d & m);
      else if (wa == A_CYC) n_cyc = (m_cyc & ~m) | (d & m);
      else if (wa == A_CMP) n_cmp = (m_cmp & ~m) | (d & m);
      else if (wa == A_STS && s[0]) begin
        if (d[0] && !set) n_flag = 1'b0;
        if (d[1]) n_halt = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_led = n_led;
    m_seg = n_seg;
    m_cyc = n_cyc;
    m_cmp = n_cmp;
    m_flag = n_flag;
    m_halt = n_halt;
    chk_regs("post");
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) op(4'h0, 1'b0, 32'h0, 4'h0, 32'h0, r);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    ce_i = 4'h0;
    #1;
    model_reset();
    chk_regs("rst");
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  function automatic vec_t mk(input logic [3:0] ce, input logic we,
                              input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.ce = ce; v.we = we; v.addr = a;
    v.sel = s; v.data = d; v.exp = e;
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic [31:0] a, d;
    logic [3:0] ce, s;
    logic we;
    int k;

    clr = 1'b0;
    ce_i = 0; we_i = 0; addr_i = 0; sel_i = 0; data_i = 0;
    @(negedge clk);
    do_reset();

    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("cyc_after_rst0", r, 32'h0);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("cyc_after_rst1", r, 32'h1);

    tbl.push_back(mk(4'hF, 1, 32'h40, 4'hF, 32'hDEADBEEF, 0));
    tbl.push_back(mk(4'hF, 0, 32'h40, 4'hF, 0, 32'hDEADBEEF));
    tbl.push_back(mk(4'h1, 0, 32'h1043, 4'h0, 0, 32'hDEADBEEF));
    tbl.push_back(mk(4'hF, 1, 32'h40, 4'h5, 32'h11223344, 0));
    tbl.push_back(mk(4'hF, 0, 32'h40, 4'hF, 0, 32'hDE22BE44));
    tbl.push_back(mk(4'hF, 0, 32'h2000_0000, 4'hF, 0, 0));
    tbl.push_back(mk(4'h0, 0, 32'h40, 4'hF, 0, 0));
    tbl.push_back(mk(4'hF, 1, 32'h2000_0000, 4'hF, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(4'hF, 1, 32'h40, 4'h0, 32'h0, 0));
    tbl.push_back(mk(4'hF, 0, 32'h40, 4'hF, 0, 32'hDE22BE44));
    tbl.push_back(mk(4'hF, 1, A_LED, 4'hF, 32'hABCD1234, 0));
    tbl.push_back(mk(4'hF, 0, A_LED + 2, 4'hF, 0, 32'h0000_1234));
    tbl.push_back(mk(4'hF, 1, A_SEG, 4'hC, 32'hCAFEF00D, 0));
    tbl.push_back(mk(4'hF, 0, A_SEG, 4'hF, 0, 32'hCAFE0000));
    tbl.push_back(mk(4'hF, 0, A_STS, 4'hF, 0, 32'h0));

    foreach (tbl[i]) begin
      op(tbl[i].ce, tbl[i].we, tbl[i].addr, tbl[i].sel,
         tbl[i].data, r);
      chk($sformatf("vec%0d", i), r, tbl[i].exp);
    end

    do_reset();
    op(4'hF, 1'b1, A_CMP, 4'hF, 32'd5, r);
    idle(4);
    chk("irq_before", {31'h0, timer_irq_o}, 32'h0);
    idle(1);
    chk("irq_set", {31'h0, timer_irq_o}, 32'h1);
    op(4'hF, 1'b1, A_STS, 4'h1, 32'h1, r);
    chk("irq_w1c", {31'h0, timer_irq_o}, 32'h0);
    op(4'hF, 1'b1, A_CYC, 4'hF, 32'd3, r);
    idle(2);
    op(4'hF, 1'b1, A_STS, 4'h1, 32'h1, r);
    chk("irq_set_wins", {31'h0, timer_irq_o}, 32'h1);

    op(4'hF, 1'b1, A_CYC, 4'hF, 32'hFFFF_FFFE, r);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("wrap0", r, 32'hFFFF_FFFE);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("wrap1", r, 32'hFFFF_FFFF);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("wrap2", r, 32'h0);

    for (int i = 0; i < 16; i++)
      op(4'hF, 1'b1, 32'(i * 4), 4'hF, $urandom, r);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if (k < 5) begin
        a[31:28] = 4'h0;
        a[AW+1:2] = 10'($urandom_range(0, 15));
      end else if (k < 9) begin
        a = A_LED + 32'(4 * $urandom_range(0, 4))
            + 32'($urandom_range(0, 3));
      end else begin
        a[31:28] = 4'($urandom_range(2, 15));
      end
      ce = 4'($urandom);
      we = 1'($urandom);
      s = 4'($urandom);
      d = $urandom;
      if ({a[31:2], 2'b00} == A_STS && $urandom_range(0, 19) != 0)
        d[1] = 1'b0;
      op(ce, we, a, s, d, r);
    end

    do_reset();
    op(4'hF, 1'b1, A_STS, 4'h1, 32'h2, r);
    chk("halt_set", {31'h0, halt_o}, 32'h1);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("frozen0", r, 32'h1);
    idle(10);
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("frozen1", r, 32'h1);
    op(4'hF, 1'b1, A_LED, 4'h3, 32'h0000_5A5A, r);
    op(4'hF, 1'b0, A_LED, 4'hF, 0, r);
    chk("led_halted", r, 32'h0000_5A5A);
    op(4'hF, 1'b1, A_SEG, 4'hF, 32'h1234_5678, r);

    #2;
    clr = 1'b0;
    #1;
    model_reset();
    chk_regs("async");
    ce_i = 4'hF; we_i = 1'b1; addr_i = A_LED;
    sel_i = 4'hF; data_i = 32'hFFFF;
    @(posedge clk);
    #1;
    chk("wr_in_rst", {16'h0, led_o}, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    op(4'hF, 1'b0, A_CYC, 4'hF, 0, r);
    chk("cyc_post_pulse", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
